// File: rtl/reservation_station_mp_if.sv
// Issue, wakeup, flush and dispatch signals of the reservation station.
// The master side is the issue stage / CDB / execution unit.
// The slave side is the station itself.
interface reservation_station_mp_if #(
  parameter int SIZE        = 16,
  parameter int ISSUE_PORTS = 2,
  parameter int CDB_PORTS   = 2,
  parameter int XLEN        = 32,
  parameter int REG_W       = 6,
  parameter int NAME_W      = 8
);
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [ISSUE_PORTS-1:0]        issue_valid;
  logic [ISSUE_PORTS*NAME_W-1:0] issue_name;
  logic [ISSUE_PORTS*XLEN-1:0]   issue_data_1;
  logic [ISSUE_PORTS*XLEN-1:0]   issue_data_2;
  logic [ISSUE_PORTS-1:0]        issue_valid_1;
  logic [ISSUE_PORTS-1:0]        issue_valid_2;
  logic [ISSUE_PORTS*REG_W-1:0]  issue_src_1;
  logic [ISSUE_PORTS*REG_W-1:0]  issue_src_2;
  logic [ISSUE_PORTS*XLEN-1:0]   issue_address;
  logic [ISSUE_PORTS*XLEN-1:0]   issue_immediate;
  logic [ISSUE_PORTS*REG_W-1:0]  issue_rrn;
  logic [ISSUE_PORTS-1:0]        issue_tag;
  logic [CDB_PORTS-1:0]          cdb_valid;
  logic [CDB_PORTS*REG_W-1:0]    cdb_rrn;
  logic [CDB_PORTS*XLEN-1:0]     cdb_result;
  logic                          delete_tag;
  logic                          clear_tag;
  logic                          full;
  logic [CNT_W-1:0]              free_count;
  logic                          feed_valid;
  logic                          feed_ready;
  logic [NAME_W-1:0]             feed_name;
  logic [XLEN-1:0]               feed_data_1;
  logic [XLEN-1:0]               feed_data_2;
  logic [XLEN-1:0]               feed_address;
  logic [XLEN-1:0]               feed_immediate;
  logic [REG_W-1:0]              feed_rrn;
  logic                          feed_tag;

  modport master (
    output issue_valid, issue_name, issue_data_1, issue_data_2, issue_valid_1, issue_valid_2,
           issue_src_1, issue_src_2, issue_address, issue_immediate, issue_rrn, issue_tag,
           cdb_valid, cdb_rrn, cdb_result, delete_tag, clear_tag, feed_ready,
    input  full, free_count, feed_valid, feed_name, feed_data_1, feed_data_2,
           feed_address, feed_immediate, feed_rrn, feed_tag
  );

  modport slave (
    input  issue_valid, issue_name, issue_data_1, issue_data_2, issue_valid_1, issue_valid_2,
           issue_src_1, issue_src_2, issue_address, issue_immediate, issue_rrn, issue_tag,
           cdb_valid, cdb_rrn, cdb_result, delete_tag, clear_tag, feed_ready,
    output full, free_count, feed_valid, feed_name, feed_data_1, feed_data_2,
           feed_address, feed_immediate, feed_rrn, feed_tag
  );
endinterface

// File: rtl/reservation_station_mp.sv
// Multi-port reservation station.
// Entries live in an unordered slot array; an age matrix keeps issue order.
// Every cycle the oldest entry with both operands valid moves into a single dispatch register.
module reservation_station_mp #(
  parameter int SIZE        = 16,
  parameter int ISSUE_PORTS = 2,
  parameter int CDB_PORTS   = 2,
  parameter int XLEN        = 32,
  parameter int REG_W       = 6,
  parameter int NAME_W      = 8
) (
  input logic                     clock,
  input logic                     reset,
  reservation_station_mp_if.slave rs
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE + 1);
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [NAME_W-1:0] name;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  s1;
    logic [REG_W-1:0]  s2;
    logic [REG_W-1:0]  rrn;
  } ent_t;

  typedef struct packed {
    logic              valid;
    logic [NAME_W-1:0] name;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  rrn;
    logic              tag;
  } feed_t;

  logic [SIZE-1:0]  busy_q, busy_d, tag_q, tag_d, v1_q, v1_d, v2_q, v2_d;
  // age_q[i][j] = 1 : entry j is older than entry i
  logic [SIZE-1:0]  age_q [SIZE];
  logic [SIZE-1:0]  age_d [SIZE];
  ent_t             ent_q [SIZE];
  ent_t             ent_d [SIZE];
  feed_t            feed_q, feed_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             full_q, full_d;

  logic             flush, commit, issue_en, sel_v, fire;
  idx_t             sel_idx;
  logic [SIZE-1:0]  ready, taken;
  logic [ISSUE_PORTS-1:0] alloc_v;
  idx_t             alloc_idx [ISSUE_PORTS];

  // An operand that is still waiting captures the first matching CDB; lower bus index wins.
  function automatic logic [XLEN:0] snoop(input logic [REG_W-1:0] src, input logic vld,
                                          input logic [XLEN-1:0] val,
                                          input logic [CDB_PORTS-1:0] cv,
                                          input logic [CDB_PORTS*REG_W-1:0] cr,
                                          input logic [CDB_PORTS*XLEN-1:0] cd);
    logic [XLEN:0] r;
    r = {vld, val};
    if (!vld)
      for (int k = CDB_PORTS - 1; k >= 0; k--)
        if (cv[k] && (cr[k*REG_W +: REG_W] == src)) r = {1'b1, cd[k*XLEN +: XLEN]};
    return r;
  endfunction

  // Select, allocate, wake up, flush and compute the next dispatch register and counters.
  always_comb begin
    busy_d    = busy_q;
    tag_d     = tag_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    age_d     = age_q;
    ent_d     = ent_q;
    feed_d    = feed_q;
    flush     = rs.delete_tag;
    commit    = rs.clear_tag && !rs.delete_tag;
    issue_en  = !full_q && !flush;
    taken     = busy_q;
    alloc_v   = '0;
    sel_v     = 1'b0;
    sel_idx   = '0;

    // flushed entries are never candidates, so the next surviving oldest can still go
    ready = busy_q & v1_q & v2_q & ~(flush ? tag_q : '0);
    for (int i = 0; i < SIZE; i++)
      if (!sel_v && ready[i] && !(|(ready & age_q[i]))) begin
        sel_v   = 1'b1;
        sel_idx = idx_t'(i);
      end
    fire = sel_v && (!feed_q.valid || rs.feed_ready) && !(flush && feed_q.valid && feed_q.tag);

    for (int p = 0; p < ISSUE_PORTS; p++) begin
      alloc_idx[p] = '0;
      if (issue_en && rs.issue_valid[p])
        for (int i = 0; i < SIZE; i++)
          if (!alloc_v[p] && !taken[i]) begin
            alloc_v[p]   = 1'b1;
            alloc_idx[p] = idx_t'(i);
            taken[i]     = 1'b1;
          end
    end

    for (int i = 0; i < SIZE; i++) begin
      {v1_d[i], ent_d[i].d1} = snoop(ent_q[i].s1, v1_q[i], ent_q[i].d1,
                                     rs.cdb_valid, rs.cdb_rrn, rs.cdb_result);
      {v2_d[i], ent_d[i].d2} = snoop(ent_q[i].s2, v2_q[i], ent_q[i].d2,
                                     rs.cdb_valid, rs.cdb_rrn, rs.cdb_result);
      if (commit) tag_d[i] = 1'b0;
      if (flush && tag_q[i]) busy_d[i] = 1'b0;
    end
    if (fire) busy_d[sel_idx] = 1'b0;

    // lower ports are processed first, so later ports see them as older
    for (int p = 0; p < ISSUE_PORTS; p++)
      if (alloc_v[p]) begin
        busy_d[alloc_idx[p]]     = 1'b1;
        tag_d[alloc_idx[p]]      = rs.issue_tag[p];
        ent_d[alloc_idx[p]].name = rs.issue_name[p*NAME_W +: NAME_W];
        ent_d[alloc_idx[p]].addr = rs.issue_address[p*XLEN +: XLEN];
        ent_d[alloc_idx[p]].imm  = rs.issue_immediate[p*XLEN +: XLEN];
        ent_d[alloc_idx[p]].s1   = rs.issue_src_1[p*REG_W +: REG_W];
        ent_d[alloc_idx[p]].s2   = rs.issue_src_2[p*REG_W +: REG_W];
        ent_d[alloc_idx[p]].rrn  = rs.issue_rrn[p*REG_W +: REG_W];
        {v1_d[alloc_idx[p]], ent_d[alloc_idx[p]].d1} =
          snoop(rs.issue_src_1[p*REG_W +: REG_W], rs.issue_valid_1[p],
                rs.issue_data_1[p*XLEN +: XLEN], rs.cdb_valid, rs.cdb_rrn, rs.cdb_result);
        {v2_d[alloc_idx[p]], ent_d[alloc_idx[p]].d2} =
          snoop(rs.issue_src_2[p*REG_W +: REG_W], rs.issue_valid_2[p],
                rs.issue_data_2[p*XLEN +: XLEN], rs.cdb_valid, rs.cdb_rrn, rs.cdb_result);
        for (int i = 0; i < SIZE; i++) age_d[i][alloc_idx[p]] = 1'b0;
        age_d[alloc_idx[p]] = ~({{(SIZE-1){1'b0}}, 1'b1} << alloc_idx[p]);
      end

    if (flush && feed_q.valid && feed_q.tag) begin
      feed_d = '0;
    end else if (fire) begin
      feed_d.valid = 1'b1;
      feed_d.name  = ent_q[sel_idx].name;
      feed_d.d1    = ent_q[sel_idx].d1;
      feed_d.d2    = ent_q[sel_idx].d2;
      feed_d.addr  = ent_q[sel_idx].addr;
      feed_d.imm   = ent_q[sel_idx].imm;
      feed_d.rrn   = ent_q[sel_idx].rrn;
      feed_d.tag   = tag_q[sel_idx] && !commit;
    end else begin
      if (rs.feed_ready) feed_d.valid = 1'b0;
      if (commit) feed_d.tag = 1'b0;
    end

    free_d = '0;
    for (int i = 0; i < SIZE; i++) free_d = free_d + CNT_W'(!busy_d[i]);
    full_d = (free_d < CNT_W'(ISSUE_PORTS));
  end

  // Control state: occupancy, tags, operand readiness, age order, dispatch register, counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      tag_q  <= '0;
      v1_q   <= '0;
      v2_q   <= '0;
      for (int i = 0; i < SIZE; i++) age_q[i] <= '0;
      feed_q <= '0;
      free_q <= CNT_W'(SIZE);
      full_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      age_q  <= age_d;
      feed_q <= feed_d;
      free_q <= free_d;
      full_q <= full_d;
    end
  end

  // Entry payload; only meaningful while the slot is busy.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  assign rs.full           = full_q;
  assign rs.free_count     = free_q;
  assign rs.feed_valid     = feed_q.valid;
  assign rs.feed_name      = feed_q.name;
  assign rs.feed_data_1    = feed_q.d1;
  assign rs.feed_data_2    = feed_q.d2;
  assign rs.feed_address   = feed_q.addr;
  assign rs.feed_immediate = feed_q.imm;
  assign rs.feed_rrn       = feed_q.rrn;
  assign rs.feed_tag       = feed_q.tag;
endmodule

// File: tb/tb_reservation_station_mp.sv
// Directed bench for reservation_station_mp with a dispatch scoreboard.
module tb_reservation_station_mp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reservation_station_mp_if #(.SIZE(16), .ISSUE_PORTS(2), .CDB_PORTS(2), .XLEN(32),
                              .REG_W(6), .NAME_W(8)) rsif ();

  reservation_station_mp #(.SIZE(16), .ISSUE_PORTS(2), .CDB_PORTS(2), .XLEN(32),
                           .REG_W(6), .NAME_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .rs    (rsif.slave)
  );

  typedef struct packed {
    logic [7:0]  name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] addr;
    logic [31:0] imm;
    logic [5:0]  rrn;
    logic        tag;
  } txn_t;

  txn_t exp_q [$];
  txn_t got, ex;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rsif.issue_valid   = '0;
    rsif.issue_valid_1 = '0;
    rsif.issue_valid_2 = '0;
    rsif.issue_tag     = '0;
    rsif.cdb_valid     = '0;
    rsif.delete_tag    = 1'b0;
    rsif.clear_tag     = 1'b0;
  endtask

  task automatic iss(input int p, input logic [7:0] nm, input logic [31:0] a, input logic va,
                     input logic [5:0] sa, input logic [31:0] b, input logic vb,
                     input logic [5:0] sb, input logic [5:0] rrn, input logic tg);
    rsif.issue_valid[p]             = 1'b1;
    rsif.issue_name[p*8 +: 8]       = nm;
    rsif.issue_data_1[p*32 +: 32]   = a;
    rsif.issue_valid_1[p]           = va;
    rsif.issue_src_1[p*6 +: 6]      = sa;
    rsif.issue_data_2[p*32 +: 32]   = b;
    rsif.issue_valid_2[p]           = vb;
    rsif.issue_src_2[p*6 +: 6]      = sb;
    rsif.issue_address[p*32 +: 32]  = 32'hA000 + 32'(nm);
    rsif.issue_immediate[p*32 +: 32] = 32'hB000 + 32'(nm);
    rsif.issue_rrn[p*6 +: 6]        = rrn;
    rsif.issue_tag[p]               = tg;
  endtask

  task automatic cdb(input int k, input logic [5:0] r, input logic [31:0] v);
    rsif.cdb_valid[k]          = 1'b1;
    rsif.cdb_rrn[k*6 +: 6]     = r;
    rsif.cdb_result[k*32 +: 32] = v;
  endtask

  task automatic expect_txn(input logic [7:0] nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] rrn, input logic tg);
    exp_q.push_back({nm, a, b, 32'hA000 + 32'(nm), 32'hB000 + 32'(nm), rrn, tg});
  endtask

  // Monitor: every accepted dispatch is matched against the oldest expected transaction.
  always @(negedge clock) begin
    if (reset && rsif.feed_valid && rsif.feed_ready) begin
      got = {rsif.feed_name, rsif.feed_data_1, rsif.feed_data_2, rsif.feed_address,
             rsif.feed_immediate, rsif.feed_rrn, rsif.feed_tag};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL feed_unexpected: got name=%0d rrn=%0d, expected no dispatch",
                 got.name, got.rrn);
      end else begin
        ex = exp_q.pop_front();
        if (got !== ex) begin
          miscompares++;
          $display("FAIL feed_txn: got name=%0d d1=%h d2=%h addr=%h imm=%h rrn=%0d tag=%0d, expected name=%0d d1=%h d2=%h addr=%h imm=%h rrn=%0d tag=%0d",
                   got.name, got.d1, got.d2, got.addr, got.imm, got.rrn, got.tag,
                   ex.name, ex.d1, ex.d2, ex.addr, ex.imm, ex.rrn, ex.tag);
        end
      end
    end
  end

  initial begin
    rsif.issue_name = '0;      rsif.issue_data_1 = '0;    rsif.issue_data_2 = '0;
    rsif.issue_src_1 = '0;     rsif.issue_src_2 = '0;     rsif.issue_address = '0;
    rsif.issue_immediate = '0; rsif.issue_rrn = '0;       rsif.cdb_rrn = '0;
    rsif.cdb_result = '0;      rsif.feed_ready = 1'b0;
    idle();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_free_count", 32'(rsif.free_count), 32'd16);
    chk("reset_full", 32'(rsif.full), 32'd0);
    chk("reset_feed_valid", 32'(rsif.feed_valid), 32'd0);
    chk("reset_feed_name", 32'(rsif.feed_name), 32'd0);
    chk("reset_feed_data", rsif.feed_data_1 | rsif.feed_data_2 | 32'(rsif.feed_rrn), 32'd0);
    @(negedge clock) reset = 1'b1;

    // Single ready ADD: minimum latency
    rsif.feed_ready = 1'b1;
    iss(0, 8'd1, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd9, 1'b0);
    expect_txn(8'd1, 32'd5, 32'd7, 6'd9, 1'b0);
    tick(); idle();
    chk("add_free_after_issue", 32'(rsif.free_count), 32'd15);
    chk("add_feed_not_yet", 32'(rsif.feed_valid), 32'd0);
    tick();
    chk("add_feed_valid", 32'(rsif.feed_valid), 32'd1);
    chk("add_free_back", 32'(rsif.free_count), 32'd16);
    tick();

    // Wakeup via CDB 1 three cycles after issue; CDB 0 carries an unrelated tag
    iss(0, 8'd2, 32'd0, 1'b0, 6'd12, 32'd3, 1'b1, 6'd0, 6'd10, 1'b0);
    expect_txn(8'd2, 32'hDEAD, 32'd3, 6'd10, 1'b0);
    tick(); idle();
    tick(); tick();
    cdb(1, 6'd12, 32'hDEAD); cdb(0, 6'd13, 32'h77);
    tick(); idle();
    repeat (3) tick();

    // Two buses match the same producer: bus 0 wins
    iss(0, 8'd3, 32'd1, 1'b1, 6'd0, 32'd0, 1'b0, 6'd20, 6'd11, 1'b0);
    expect_txn(8'd3, 32'd1, 32'h111, 6'd11, 1'b0);
    tick(); idle(); tick();
    cdb(0, 6'd20, 32'h111); cdb(1, 6'd20, 32'h222);
    tick(); idle();
    repeat (3) tick();

    // Same-cycle bypass on issue
    iss(0, 8'd17, 32'hBAD, 1'b0, 6'd12, 32'd4, 1'b1, 6'd0, 6'd12, 1'b0);
    cdb(1, 6'd12, 32'hBEEF); cdb(0, 6'd13, 32'h77);
    expect_txn(8'd17, 32'hBEEF, 32'd4, 6'd12, 1'b0);
    tick(); idle();
    repeat (3) tick();
    chk("wakeup_free_back", 32'(rsif.free_count), 32'd16);

    // Fill 15 entries with operands waiting on distinct producers
    for (int c = 0; c < 8; c++) begin
      iss(0, 8'd4, 32'd0, 1'b0, 6'(32 + 2*c), 32'(2*c), 1'b1, 6'd0, 6'(2*c), 1'b0);
      if (c < 7)
        iss(1, 8'd4, 32'd0, 1'b0, 6'(33 + 2*c), 32'(2*c+1), 1'b1, 6'd0, 6'(2*c+1), 1'b0);
      tick(); idle();
    end
    chk("fill_free_count", 32'(rsif.free_count), 32'd1);
    chk("fill_full", 32'(rsif.full), 32'd1);
    iss(0, 8'd18, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd1, 1'b0);
    iss(1, 8'd18, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd2, 1'b0);
    tick(); idle();
    chk("full_ignores_issue", 32'(rsif.free_count), 32'd1);
    cdb(0, 6'd32, 32'h500);
    expect_txn(8'd4, 32'h500, 32'd0, 6'd0, 1'b0);
    tick(); idle(); tick();
    chk("drain_one_free_count", 32'(rsif.free_count), 32'd2);
    chk("drain_one_full", 32'(rsif.full), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midreset_free_count", 32'(rsif.free_count), 32'd16);
    chk("midreset_feed_valid", 32'(rsif.feed_valid), 32'd0);
    @(negedge clock) reset = 1'b1;

    // Age beats slot index: A sits in slot 1, younger B reuses slot 0
    rsif.feed_ready = 1'b0;
    iss(0, 8'd7, 32'h70, 1'b1, 6'd0, 32'h71, 1'b1, 6'd0, 6'd7, 1'b0);
    iss(1, 8'd5, 32'h50, 1'b1, 6'd0, 32'h51, 1'b1, 6'd0, 6'd5, 1'b0);
    expect_txn(8'd7, 32'h70, 32'h71, 6'd7, 1'b0);
    expect_txn(8'd5, 32'h50, 32'h51, 6'd5, 1'b0);
    expect_txn(8'd6, 32'h60, 32'h61, 6'd6, 1'b0);
    tick(); idle(); tick();
    chk("hold_first", 32'(rsif.feed_name), 32'd7);
    iss(0, 8'd6, 32'h60, 1'b1, 6'd0, 32'h61, 1'b1, 6'd0, 6'd6, 1'b0);
    tick(); idle();
    chk("hold_stable_1", 32'(rsif.feed_name), 32'd7);
    tick();
    chk("hold_stable_2", 32'(rsif.feed_data_1), 32'h70);
    chk("hold_free_count", 32'(rsif.free_count), 32'd14);
    rsif.feed_ready = 1'b1;
    tick();
    chk("b2b_older_next", 32'(rsif.feed_name), 32'd5);
    tick();
    chk("b2b_younger_last", 32'(rsif.feed_name), 32'd6);
    tick();
    chk("b2b_free_back", 32'(rsif.free_count), 32'd16);

    // Flush with a tagged instruction held in the dispatch register
    rsif.feed_ready = 1'b0;
    iss(0, 8'd8, 32'd8, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 6'd8, 1'b1);
    tick(); idle(); tick();
    iss(0, 8'd9,  32'd9,  1'b1, 6'd0, 32'd9,  1'b1, 6'd0, 6'd9,  1'b1);
    iss(1, 8'd10, 32'd10, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 6'd10, 1'b0);
    tick(); idle();
    iss(0, 8'd11, 32'd11, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 6'd11, 1'b1);
    iss(1, 8'd12, 32'd12, 1'b1, 6'd0, 32'd12, 1'b1, 6'd0, 6'd12, 1'b0);
    tick(); idle();
    chk("preflush_free_count", 32'(rsif.free_count), 32'd12);
    chk("preflush_feed_tag", 32'(rsif.feed_tag), 32'd1);
    rsif.delete_tag = 1'b1;
    tick(); idle();
    chk("flush_free_count", 32'(rsif.free_count), 32'd14);
    chk("flush_feed_valid", 32'(rsif.feed_valid), 32'd0);
    chk("flush_feed_name", 32'(rsif.feed_name), 32'd0);
    expect_txn(8'd10, 32'd10, 32'd10, 6'd10, 1'b0);
    expect_txn(8'd12, 32'd12, 32'd12, 6'd12, 1'b0);
    rsif.feed_ready = 1'b1;
    repeat (4) tick();

    // Commit, then delete: nothing is flushed
    rsif.feed_ready = 1'b0;
    iss(0, 8'd13, 32'd13, 1'b1, 6'd0, 32'd13, 1'b1, 6'd0, 6'd13, 1'b1);
    iss(1, 8'd14, 32'd14, 1'b1, 6'd0, 32'd14, 1'b1, 6'd0, 6'd14, 1'b1);
    tick(); idle(); tick();
    chk("commit_pre_tag", 32'(rsif.feed_tag), 32'd1);
    rsif.clear_tag = 1'b1;
    tick(); idle();
    chk("commit_feed_tag", 32'(rsif.feed_tag), 32'd0);
    rsif.delete_tag = 1'b1;
    tick(); idle();
    chk("commit_then_delete_free", 32'(rsif.free_count), 32'd15);
    chk("commit_then_delete_feed", 32'(rsif.feed_valid), 32'd1);
    expect_txn(8'd13, 32'd13, 32'd13, 6'd13, 1'b0);
    expect_txn(8'd14, 32'd14, 32'd14, 6'd14, 1'b0);
    rsif.feed_ready = 1'b1;
    repeat (4) tick();

    // Delete and commit together: delete wins
    rsif.feed_ready = 1'b0;
    iss(0, 8'd15, 32'd15, 1'b1, 6'd0, 32'd15, 1'b1, 6'd0, 6'd15, 1'b1);
    iss(1, 8'd16, 32'd16, 1'b1, 6'd0, 32'd16, 1'b1, 6'd0, 6'd16, 1'b1);
    tick(); idle();
    iss(0, 8'd19, 32'd19, 1'b1, 6'd0, 32'd19, 1'b1, 6'd0, 6'd19, 1'b0);
    tick(); idle();
    chk("both_pre_free", 32'(rsif.free_count), 32'd14);
    rsif.delete_tag = 1'b1;
    rsif.clear_tag  = 1'b1;
    tick(); idle();
    chk("both_free_count", 32'(rsif.free_count), 32'd15);
    chk("both_feed_valid", 32'(rsif.feed_valid), 32'd0);
    expect_txn(8'd19, 32'd19, 32'd19, 6'd19, 1'b0);
    rsif.feed_ready = 1'b1;

    for (int n = 0; n < 30 && exp_q.size() != 0; n++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    chk("final_free_count", 32'(rsif.free_count), 32'd16);
    chk("final_feed_valid", 32'(rsif.feed_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
